weight_preload_sequencer: RTL and testbench

- Producer end of the mesh preload interface (preload_valid / preload_addr / preload_data), followed by the start pulse to the FSM controller.
- Accepts a host weight stream over valid/ready and writes it into the ROWS x COLS PE weight registers in row-major order.
- After a configurable gap, issues a single-cycle start.
- Sits between the host/DMA side and the array top.

---
 rtl/weight_preload_sequencer.sv | 182 ++++++++++++++++++
 tb/tb_weight_preload_sequencer.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_preload_sequencer.sv
// rtl/weight_preload_sequencer.sv - host weight stream to mesh preload writer with start pulse
//
// Purpose:
//   Accepts a host weight stream over a valid/ready handshake and writes each
//   beat into the ROWS x COLS PE weight registers in row-major order through
//   the mesh preload interface. After the last write and a START_GAP cycle gap,
//   a single-cycle start/done pulse is issued to the array controller.
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   load_req      in   begin a full-array load (sampled only when idle)
//   abort         in   cancel the current load, return to idle
//   w_valid       in   host weight valid
//   w_ready       out  sequencer can accept a weight (combinational)
//   w_data        in   signed host weight, DW bits
//   preload_valid out  preload write strobe, one cycle after each accept
//   preload_addr  out  {row, col}, row in the upper ROW_W bits
//   preload_data  out  weight bit pattern, unmodified
//   start         out  one-cycle compute start pulse
//   busy          out  high whenever not idle
//   done          out  one-cycle pulse, coincident with start
//   checksum      out  (PRELOAD_CHECKSUM_EN only) 16-bit running sum of the
//                      sign-extended accepted weights of the current load
//
// Optional feature macro: PRELOAD_CHECKSUM_EN

module weight_preload_sequencer #(
  parameter int DW        = 8,
  parameter int ROWS      = 16,
  parameter int COLS      = 16,
  parameter int ROW_W     = 4,
  parameter int COL_W     = 4,
  parameter int START_GAP = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_req,
  input  logic                   abort,
  input  logic                   w_valid,
  output logic                   w_ready,
  input  logic [DW-1:0]          w_data,
  output logic                   preload_valid,
  output logic [ROW_W+COL_W-1:0] preload_addr,
  output logic [DW-1:0]          preload_data,
  output logic                   start,
  output logic                   busy,
  output logic                   done
`ifdef PRELOAD_CHECKSUM_EN
  ,
  output logic [15:0]            checksum
`endif
);

  // Gap counter must be able to hold START_GAP; keep at least one bit for START_GAP=0.
  localparam int GAP_W = (START_GAP < 1) ? 1 : $clog2(START_GAP + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    GAP  = 2'd2,
    FIRE = 2'd3
  } state_t;

  state_t             state_q;
  state_t             state_d;
  logic [ROW_W-1:0]   row_cnt;
  logic [COL_W-1:0]   col_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               last_col;
  logic               last_cell;
  logic               accept;

  assign last_col  = (col_cnt == COL_W'(COLS - 1));
  assign last_cell = last_col && (row_cnt == ROW_W'(ROWS - 1));

  // Accept is derived directly from state/inputs rather than from w_ready so
  // the datapath does not depend on the FSM output block.
  assign accept = (state_q == LOAD) && !abort && w_valid;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and FSM outputs
  always_comb begin
    state_d = state_q;
    w_ready = 1'b0;
    start   = 1'b0;
    done    = 1'b0;
    busy    = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        // abort has priority over a simultaneous load_req
        if (load_req && !abort) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        w_ready = !abort;
        if (abort) begin
          state_d = IDLE;
        end else if (w_valid && last_cell) begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (abort) begin
          state_d = IDLE;
        end else if (gap_cnt == GAP_W'(START_GAP)) begin
          state_d = FIRE;
        end
      end
      FIRE: begin
        // An abort landing on the fire cycle suppresses the pulse.
        start   = !abort;
        done    = !abort;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Counters and registered preload outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_cnt       <= '0;
      col_cnt       <= '0;
      gap_cnt       <= '0;
      preload_valid <= 1'b0;
      preload_addr  <= '0;
      preload_data  <= '0;
    end else begin
      preload_valid <= accept;
      if (accept) begin
        preload_addr <= {row_cnt, col_cnt};
        preload_data <= w_data;
      end

      // Counters only live while the next state is LOAD; leaving LOAD for any
      // reason (finish, abort) clears them so the next load starts at {0,0}.
      if (state_d != LOAD) begin
        row_cnt <= '0;
        col_cnt <= '0;
      end else if (accept) begin
        if (last_col) begin
          col_cnt <= '0;
          row_cnt <= row_cnt + 1'b1;
        end else begin
          col_cnt <= col_cnt + 1'b1;
        end
      end

      if ((state_q == GAP) && (state_d == GAP)) begin
        gap_cnt <= gap_cnt + 1'b1;
      end else begin
        gap_cnt <= '0;
      end
    end
  end

`ifdef PRELOAD_CHECKSUM_EN
  // Cleared on LOAD entry only; abort leaves the partial sum visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if ((state_q == IDLE) && (state_d == LOAD)) begin
      checksum <= '0;
    end else if (accept) begin
      checksum <= checksum + 16'($signed(w_data));
    end
  end
`endif

endmodule

// File: tb/tb_weight_preload_sequencer.sv
// tb/tb_weight_preload_sequencer.sv - self-checking bench for weight_preload_sequencer

module tb_weight_preload_sequencer;

  localparam int DW        = 8;
  localparam int ROWS      = 16;
  localparam int COLS      = 16;
  localparam int ROW_W     = 4;
  localparam int COL_W     = 4;
  localparam int START_GAP = 2;
  localparam int N         = ROWS * COLS;

  logic                   clk      = 1'b0;
  logic                   rst      = 1'b1;
  logic                   load_req = 1'b0;
  logic                   abort    = 1'b0;
  logic                   w_valid  = 1'b0;
  logic [DW-1:0]          w_data   = '0;
  logic                   w_ready;
  logic                   preload_valid;
  logic [ROW_W+COL_W-1:0] preload_addr;
  logic [DW-1:0]          preload_data;
  logic                   start;
  logic                   busy;
  logic                   done;
`ifdef PRELOAD_CHECKSUM_EN
  logic [15:0]            checksum;
`endif

  int n_pass  = 0;
  int n_total = 0;

  weight_preload_sequencer #(
    .DW(DW), .ROWS(ROWS), .COLS(COLS), .ROW_W(ROW_W), .COL_W(COL_W), .START_GAP(START_GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load_req(load_req),
    .abort(abort),
    .w_valid(w_valid),
    .w_ready(w_ready),
    .w_data(w_data),
    .preload_valid(preload_valid),
    .preload_addr(preload_addr),
    .preload_data(preload_data),
    .start(start),
    .busy(busy),
    .done(done)
`ifdef PRELOAD_CHECKSUM_EN
    ,
    .checksum(checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    #1;
    n_total++;
    if ({preload_valid, preload_addr, preload_data, start, done, busy, w_ready} !== '0) begin
      $display("FAIL reset_outputs got v=%0b a=%0h d=%0h s=%0b dn=%0b b=%0b r=%0b want all 0",
               preload_valid, preload_addr, preload_data, start, done, busy, w_ready);
    end else n_pass++;
`ifdef PRELOAD_CHECKSUM_EN
    n_total++;
    if (checksum !== 16'h0000) $display("FAIL reset_checksum got %0h want 0", checksum);
    else n_pass++;
`endif
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0 || w_ready !== 1'b0) $display("FAIL post_reset_idle got busy=%0b w_ready=%0b want 0 0", busy, w_ready);
    else n_pass++;
  endtask

  // mode: 0 valid high data=i%128, 1 valid toggling, 2 random valid/data, 3 all 0xFF, 4 all 0x01
  // abort_after: number of accepted beats before abort is raised (-1 = never)
  // pulse_req: pulse load_req during LOAD and in the first GAP cycle
  task automatic do_load(input int mode, input int abort_after, input bit pulse_req, input string name);
    logic [DW-1:0] sent[$];
    int  beats     = 0;
    int  writes    = 0;
    int  last_wr   = -1;
    int  abort_cyc = -1;
    int  sum       = 0;
    bit  pend      = 1'b0;
    bit  aborted   = 1'b0;
    bit  finished  = 1'b0;
    bit  in_load;
    bit  exp_start;
    bit  exp_ready;
    @(negedge clk);
    w_valid  = 1'b0;
    abort    = 1'b0;
    load_req = 1'b1;
    for (int cyc = 0; cyc < 4000 && !finished; cyc++) begin
      @(negedge clk);
      in_load = !aborted && (beats < N);

      n_total++;
      if (preload_valid !== pend) $display("FAIL %s preload_valid cyc=%0d got %0b want %0b", name, cyc, preload_valid, pend);
      else n_pass++;
      if (pend) begin
        n_total++;
        if (preload_addr !== (ROW_W+COL_W)'(writes) || preload_data !== sent[writes])
          $display("FAIL %s write%0d got addr=%0h data=%0h want addr=%0h data=%0h",
                   name, writes, preload_addr, preload_data, writes, sent[writes]);
        else n_pass++;
        writes++;
        if (writes == N) last_wr = cyc;
      end

      exp_start = (last_wr >= 0) && (cyc == last_wr + START_GAP + 1);
      n_total++;
      if (start !== exp_start || done !== exp_start)
        $display("FAIL %s start_done cyc=%0d got start=%0b done=%0b want %0b", name, cyc, start, done, exp_start);
      else n_pass++;

      if (in_load) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy_load got %0b want 1", name, busy);
        else n_pass++;
      end

      if (exp_start) begin
        n_total++;
        if (busy !== 1'b1) $display("FAIL %s busy_fire got %0b want 1", name, busy);
        else n_pass++;
`ifdef PRELOAD_CHECKSUM_EN
        n_total++;
        if (checksum !== 16'(sum)) $display("FAIL %s checksum got %0h want %0h", name, checksum, 16'(sum));
        else n_pass++;
`endif
      end

      if (last_wr >= 0 && cyc == last_wr + START_GAP + 2) begin
        n_total++;
        if (busy !== 1'b0 || writes != N) $display("FAIL %s end_of_load got busy=%0b writes=%0d want 0 %0d", name, busy, writes, N);
        else n_pass++;
        finished = 1'b1;
      end

      if (aborted && cyc == abort_cyc + 1) begin
        n_total++;
        if (busy !== 1'b0) $display("FAIL %s busy_after_abort got %0b want 0", name, busy);
        else n_pass++;
      end

      if (aborted && cyc == abort_cyc + 8) begin
        n_total++;
        if (writes != abort_after || busy !== 1'b0)
          $display("FAIL %s abort_writes got %0d busy=%0b want %0d 0", name, writes, busy, abort_after);
        else n_pass++;
        finished = 1'b1;
      end

      if (!finished) begin
        load_req = pulse_req && ((in_load && beats == 50) || (last_wr >= 0 && cyc == last_wr));
        abort    = in_load && (beats == abort_after);
        case (mode)
          0: begin w_valid = 1'b1; w_data = DW'(beats % 128); end
          1: begin w_valid = (cyc % 2 == 0); w_data = DW'($urandom); end
          2: begin w_valid = ($urandom_range(0, 3) != 0); w_data = DW'($urandom); end
          3: begin w_valid = 1'b1; w_data = 8'hFF; end
          default: begin w_valid = 1'b1; w_data = 8'h01; end
        endcase
        #1;
        exp_ready = in_load && !abort;
        n_total++;
        if (w_ready !== exp_ready) $display("FAIL %s w_ready cyc=%0d got %0b want %0b", name, cyc, w_ready, exp_ready);
        else n_pass++;
        pend = w_valid && exp_ready;
        if (pend) begin
          sent.push_back(w_data);
          sum += int'($signed(w_data));
          beats++;
        end
        if (abort) begin
          aborted   = 1'b1;
          abort_cyc = cyc;
        end
      end
    end
    load_req = 1'b0;
    abort    = 1'b0;
    w_valid  = 1'b0;
    if (!finished) begin
      n_total++;
      $display("FAIL %s timeout got writes=%0d want completion", name, writes);
    end
  endtask

  task automatic test_idle_abort();
    @(negedge clk);
    abort    = 1'b1;
    load_req = 1'b1;
    @(negedge clk);
    abort    = 1'b0;
    load_req = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0 || w_ready !== 1'b0) $display("FAIL idle_abort got busy=%0b w_ready=%0b want 0 0", busy, w_ready);
    else n_pass++;
    @(negedge clk);
    n_total++;
    if (busy !== 1'b0) $display("FAIL idle_abort_hold got busy=%0b want 0", busy);
    else n_pass++;
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    load_req = 1'b1;
    @(negedge clk);
    load_req = 1'b0;
    w_valid  = 1'b1;
    w_data   = 8'h5A;
    repeat (40) @(negedge clk);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_total++;
    if ({preload_valid, preload_addr, preload_data, start, done, busy, w_ready} !== '0)
      $display("FAIL async_reset got v=%0b a=%0h d=%0h s=%0b dn=%0b b=%0b r=%0b want all 0",
               preload_valid, preload_addr, preload_data, start, done, busy, w_ready);
    else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_total++;
      if (w_ready !== 1'b0 || busy !== 1'b0 || preload_valid !== 1'b0)
        $display("FAIL post_async_reset got w_ready=%0b busy=%0b v=%0b want 0 0 0", w_ready, busy, preload_valid);
      else n_pass++;
    end
    w_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    do_load(0, -1, 1'b0, "full");
    do_load(1, -1, 1'b0, "toggle");
    do_load(2, -1, 1'b0, "random");
    do_load(0, 100, 1'b0, "abort");
    do_load(2, -1, 1'b0, "restart");
    do_load(0, -1, 1'b1, "ignore_req");
    test_idle_abort();
    test_async_reset();
    do_load(1, -1, 1'b0, "after_rst");
`ifdef PRELOAD_CHECKSUM_EN
    do_load(3, -1, 1'b0, "minus_one");
    n_total++;
    if (checksum !== 16'hFF00) $display("FAIL checksum_minus_one got %0h want ff00", checksum);
    else n_pass++;
    do_load(4, -1, 1'b0, "plus_one");
    n_total++;
    if (checksum !== 16'h0100) $display("FAIL checksum_plus_one got %0h want 0100", checksum);
    else n_pass++;
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
